// File: rtl/tpu_tile_sequencer_if.sv
// Handshake and bus bundle between the tile sequencer and its surroundings.
// The master side drives the run request, configuration and FIFO status.
// The slave side (the sequencer) drives the strobes and addresses.
interface tpu_tile_sequencer_if #(
   parameter int ADDRESSSIZE = 10,
   parameter int TILE_BW     = 4
);
   // Run control and configuration
   logic                   start;
   logic                   abort;
   logic [ADDRESSSIZE-1:0] cfg_in_base;
   logic [ADDRESSSIZE-1:0] cfg_out_base;
   logic [ADDRESSSIZE-1:0] cfg_rows;
   logic [TILE_BW-1:0]     cfg_tiles;
   logic                   cfg_acc;
   logic                   fifo_empty;

   // Sequencer outputs
   logic                   fifo_read_enable;
   logic                   we_rl;
   logic                   ub_rd_en;
   logic [ADDRESSSIZE-1:0] ub_addr;
   logic                   res_we;
   logic                   res_acc;
   logic [ADDRESSSIZE-1:0] res_addr;
   logic                   busy;
   logic                   done;

   modport master (
      output start, abort, cfg_in_base, cfg_out_base, cfg_rows, cfg_tiles, cfg_acc, fifo_empty,
      input  fifo_read_enable, we_rl, ub_rd_en, ub_addr, res_we, res_acc, res_addr, busy, done
   );

   modport slave (
      input  start, abort, cfg_in_base, cfg_out_base, cfg_rows, cfg_tiles, cfg_acc, fifo_empty,
      output fifo_read_enable, we_rl, ub_rd_en, ub_addr, res_we, res_acc, res_addr, busy, done
   );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Run controller for the TPU tile loop: per tile, pop one weight set, reload the
// systolic array, stream R input vectors from the unified buffer and write the
// delayed results to the results SRAM. A run covers T tiles and ends with a
// one-cycle done pulse. All strobes come straight from flops; the FSM decides
// each strobe one cycle ahead of the cycle in which it is visible.
module tpu_tile_sequencer #(
   parameter int ADDRESSSIZE = 10,
   parameter int MATRIX_SIZE = 8,
   parameter int PIPE_LAT    = 3 * MATRIX_SIZE,
   parameter int TILE_BW     = 4
) (
   input logic                 clk,
   input logic                 rstn,
   tpu_tile_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WLOAD,
      S_WRL,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                 state_q;

   // Latched run configuration
   logic [ADDRESSSIZE-1:0] out_base_q;
   logic [ADDRESSSIZE-1:0] rows_q;
   logic [TILE_BW-1:0]     tiles_q;
   logic                   acc_q;

   // Progress counters
   logic [TILE_BW-1:0]     tile_q;
   logic [ADDRESSSIZE-1:0] rd_cnt_q;
   logic [ADDRESSSIZE-1:0] res_cnt_q;
   logic [ADDRESSSIZE-1:0] ub_next_q;

   // Registered outputs
   logic                   pop_q;
   logic                   we_rl_q;
   logic                   ub_rd_en_q;
   logic [ADDRESSSIZE-1:0] ub_addr_q;
   logic [ADDRESSSIZE-1:0] res_addr_q;
   logic                   res_acc_q;
   logic                   busy_q;
   logic                   done_q;

   // Result-valid pipeline: bit PIPE_LAT-1 is the results SRAM write strobe
   logic [PIPE_LAT-1:0]    vld_q;
   logic                   res_we;

   assign res_we = vld_q[PIPE_LAT-1];

   // Last result of the current tile is being written in this cycle
   logic                   tile_res_last;
   logic                   tile_is_last;

   assign tile_res_last = res_we && (res_cnt_q == rows_q - ADDRESSSIZE'(1));
   assign tile_is_last  = (tile_q == tiles_q - TILE_BW'(1));

   generate
      for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_vld
         logic stage_d;
         if (gi == 0) begin : g_head
            assign stage_d = ub_rd_en_q;
         end else begin : g_tail
            assign stage_d = vld_q[gi-1];
         end
         // One stage of the valid delay line; abort flushes in-flight results
         always_ff @(posedge clk) begin
            if (!rstn || bus.abort) begin
               vld_q[gi] <= 1'b0;
            end else begin
               vld_q[gi] <= stage_d;
            end
         end
      end
   endgenerate

   // Run FSM with look-ahead registered strobes and address/counter bookkeeping
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         out_base_q <= '0;
         rows_q     <= '0;
         tiles_q    <= '0;
         acc_q      <= 1'b0;
         tile_q     <= '0;
         rd_cnt_q   <= '0;
         res_cnt_q  <= '0;
         ub_next_q  <= '0;
         pop_q      <= 1'b0;
         we_rl_q    <= 1'b0;
         ub_rd_en_q <= 1'b0;
         ub_addr_q  <= '0;
         res_addr_q <= '0;
         res_acc_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (bus.abort) begin
         state_q    <= S_IDLE;
         pop_q      <= 1'b0;
         we_rl_q    <= 1'b0;
         ub_rd_en_q <= 1'b0;
         res_acc_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         pop_q      <= 1'b0;
         we_rl_q    <= 1'b0;
         ub_rd_en_q <= 1'b0;
         done_q     <= 1'b0;

         // Result rows advance with every write, whatever the FSM is doing
         if (res_we) begin
            res_addr_q <= res_addr_q + ADDRESSSIZE'(1);
            res_cnt_q  <= res_cnt_q + ADDRESSSIZE'(1);
         end

         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  out_base_q <= bus.cfg_out_base;
                  rows_q     <= bus.cfg_rows;
                  tiles_q    <= bus.cfg_tiles;
                  acc_q      <= bus.cfg_acc;
                  ub_next_q  <= bus.cfg_in_base;
                  res_addr_q <= bus.cfg_out_base;
                  tile_q     <= '0;
                  rd_cnt_q   <= '0;
                  res_cnt_q  <= '0;
                  res_acc_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  if (bus.cfg_rows == '0 || bus.cfg_tiles == '0) begin
                     // Empty run: spend one DONE cycle without the pulse, then pulse
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WLOAD;
                     pop_q   <= !bus.fifo_empty;
                  end
               end
            end

            S_WLOAD: begin
               if (pop_q) begin
                  // FIFO data is valid the cycle after the pop
                  state_q <= S_WRL;
                  we_rl_q <= 1'b1;
               end else begin
                  pop_q <= !bus.fifo_empty;
               end
            end

            S_WRL: begin
               state_q    <= S_STREAM;
               ub_rd_en_q <= 1'b1;
               ub_addr_q  <= ub_next_q;
               ub_next_q  <= ub_next_q + ADDRESSSIZE'(1);
               rd_cnt_q   <= ADDRESSSIZE'(1);
            end

            S_STREAM: begin
               if (rd_cnt_q == rows_q) begin
                  state_q <= S_DRAIN;
               end else begin
                  ub_rd_en_q <= 1'b1;
                  ub_addr_q  <= ub_next_q;
                  ub_next_q  <= ub_next_q + ADDRESSSIZE'(1);
                  rd_cnt_q   <= rd_cnt_q + ADDRESSSIZE'(1);
               end
            end

            S_DRAIN: begin
               // Next weight reload only once the tile's last result is written
               if (tile_res_last) begin
                  res_cnt_q <= '0;
                  rd_cnt_q  <= '0;
                  if (tile_is_last) begin
                     state_q   <= S_DONE;
                     done_q    <= 1'b1;
                     res_acc_q <= 1'b0;
                  end else begin
                     state_q   <= S_WLOAD;
                     tile_q    <= tile_q + TILE_BW'(1);
                     pop_q     <= !bus.fifo_empty;
                     res_acc_q <= acc_q;
                     if (acc_q) begin
                        res_addr_q <= out_base_q;
                     end
                  end
               end
            end

            S_DONE: begin
               if (done_q) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  done_q <= 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifo_read_enable = pop_q;
   assign bus.we_rl            = we_rl_q;
   assign bus.ub_rd_en         = ub_rd_en_q;
   assign bus.ub_addr          = ub_addr_q;
   assign bus.res_we           = res_we;
   assign bus.res_acc          = res_acc_q;
   assign bus.res_addr         = res_addr_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;

endmodule
